// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command transceiver.
package uart_pkg;

   // Parity selection as carried by the PARITY parameter.
   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   // Bit positions inside rsp_err.
   localparam int ERR_PAR = 0;
   localparam int ERR_FRM = 1;
   localparam int ERR_TMO = 2;
   localparam int ERR_W   = 3;

   // Main transaction FSM.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_BYTE,
      ST_RX_WAIT,
      ST_RX_BYTE,
      ST_DONE
   } state_e;

   // Receive-frame FSM.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_e;

   // Clocks per bit, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// Receive side of one UART frame: synchroniser, start-bit validation and
// mid-bit sampling. Held idle whenever en_i is low.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DIV       = 10,
   parameter int DATA_BITS = 8,
   parameter bit PAR_EN    = 1'b1,
   parameter bit ODD_PAR   = 1'b0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 rx_i,
   output logic                 start_ok_o,
   output logic [DATA_BITS-1:0] byte_o,
   output logic                 byte_vld_o,
   output logic                 par_err_o,
   output logic                 frm_err_o
);

   localparam int TW = $clog2(DIV);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TIM_MAX   = TW'(DIV - 1);
   localparam logic [TW-1:0] TIM_HALF  = TW'(DIV / 2 - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

   logic                 sync1_q, sync2_q, dly_q;
   rx_state_e            st_q;
   logic [TW-1:0]        tim_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] sh_q;
   logic [DATA_BITS-1:0] byte_q;
   logic                 start_ok_q, byte_vld_q, par_err_q, frm_err_q;
   logic                 fall;

   assign fall = dly_q & ~sync2_q;

   // Two-flop synchroniser plus a delay flop for falling-edge detection; idle-high after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         dly_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking so each stage takes the previous stage's old value, forming a real shift chain.
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
      end
   end

   // Frame FSM: validate start at half a bit, then sample each bit at its mid-point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= RX_IDLE;
         tim_q      <= '0;
         idx_q      <= '0;
         sh_q       <= '0;
         byte_q     <= '0;
         start_ok_q <= 1'b0;
         byte_vld_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         start_ok_q <= 1'b0;
         byte_vld_q <= 1'b0;
         if (!en_i) begin
            st_q  <= RX_IDLE;
            tim_q <= '0;
            idx_q <= '0;
         end else begin
            case (st_q)
               RX_IDLE: begin
                  if (fall) begin
                     st_q  <= RX_START;
                     tim_q <= '0;
                  end
               end
               RX_START: begin
                  if (tim_q == TIM_HALF) begin
                     tim_q <= '0;
                     if (!sync2_q) begin
                        st_q       <= RX_DATA;
                        idx_q      <= '0;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        start_ok_q <= 1'b1;
                     end else begin
                        // Line went back high: glitch, not a start bit.
                        st_q <= RX_IDLE;
                     end
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               RX_DATA: begin
                  if (tim_q == TIM_MAX) begin
                     tim_q <= '0;
                     sh_q  <= {sync2_q, sh_q[DATA_BITS-1:1]};
                     if (idx_q == DATA_LAST) begin
                        idx_q <= '0;
                        st_q  <= PAR_EN ? RX_PAR : RX_STOP;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               RX_PAR: begin
                  if (tim_q == TIM_MAX) begin
                     tim_q     <= '0;
                     par_err_q <= sync2_q ^ (^sh_q) ^ ODD_PAR;
                     st_q      <= RX_STOP;
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               RX_STOP: begin
                  if (tim_q == TIM_MAX) begin
                     tim_q     <= '0;
                     frm_err_q <= frm_err_q | ~sync2_q;
                     if (idx_q == STOP_LAST) begin
                        idx_q      <= '0;
                        byte_q     <= sh_q;
                        byte_vld_q <= 1'b1;
                        st_q       <= RX_IDLE;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               default: st_q <= RX_IDLE;
            endcase
         end
      end
   end

   assign start_ok_o = start_ok_q;
   assign byte_o     = byte_q;
   assign byte_vld_o = byte_vld_q;
   assign par_err_o  = par_err_q;
   assign frm_err_o  = frm_err_q;

endmodule

// File: rtl/uart_cmd_xcvr.sv
// UART command transceiver: sends a CMD_BYTES command MS byte first and, for
// reads, collects RSP_BYTES response bytes into one word with error flags.
module uart_cmd_xcvr
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int CMD_BYTES    = 2,
   parameter int RSP_BYTES    = 1,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CMD_BYTES*DATA_BITS-1:0] cmd_data,
   input  logic                           cmd_vld,
   output logic                           cmd_rdy,
   output logic                           tx,
   input  logic                           rx,
   output logic [RSP_BYTES*DATA_BITS-1:0] rsp_data,
   output logic                           rsp_vld,
   output logic [ERR_W-1:0]               rsp_err,
   output logic                           busy
);

   // DIV must be at least 8 for the half-bit start validation to be meaningful.
   localparam int DIV     = calc_div(CLK_FREQ, BAUD);
   localparam int DW      = DATA_BITS;
   localparam int CW      = CMD_BYTES * DW;
   localparam int RW      = RSP_BYTES * DW;
   localparam bit PAR_EN  = (PARITY != int'(PAR_NONE));
   localparam bit ODD_PAR = (PARITY == int'(PAR_ODD));
   localparam int NBITS   = 1 + DW + (PAR_EN ? 1 : 0) + STOP_BITS;
   localparam int TW      = $clog2(DIV);
   localparam int BW      = $clog2(NBITS);
   localparam int CBW     = $clog2(CMD_BYTES + 1);
   localparam int RBW     = $clog2(RSP_BYTES + 1);
   localparam int TOW     = $clog2(TIMEOUT_BITS * DIV);

   localparam logic [TW-1:0]  TIM_MAX   = TW'(DIV - 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(NBITS - 1);
   localparam logic [CBW-1:0] CMD_LAST  = CBW'(CMD_BYTES - 1);
   localparam logic [RBW-1:0] RSP_LAST  = RBW'(RSP_BYTES - 1);
   localparam logic [TOW-1:0] TO_MAX    = TOW'(TIMEOUT_BITS * DIV - 1);

   state_e           state_q;
   logic             cmd_rdy_q, tx_q, rw_q, rsp_vld_q;
   logic [CW-1:0]    cmd_sh_q;
   logic [TW-1:0]    tim_q;
   logic [BW-1:0]    bit_q;
   logic [CBW-1:0]   byte_q;
   logic [RBW-1:0]   rx_cnt_q;
   logic [TOW-1:0]   to_q;
   logic [RW-1:0]    rsp_q;
   logic [ERR_W-1:0] err_q;

   logic             accept, rx_en;
   logic [DW-1:0]    cur_byte;
   logic [NBITS-1:0] tx_frame;
   logic [BW-1:0]    bit_nxt;
   logic             start_ok, byte_vld, par_err, frm_err;
   logic [DW-1:0]    rx_byte;

   assign accept = cmd_vld & cmd_rdy_q;
   assign rx_en  = (state_q == ST_RX_WAIT) || (state_q == ST_RX_BYTE);

   // Full frame of the byte currently at the top of the command shifter.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a bit unassigned and infers a latch.
      cur_byte    = cmd_sh_q[CW-1 -: DW];
      tx_frame    = '1;
      tx_frame[0] = 1'b0;
      tx_frame[DW:1] = cur_byte;
      if (PAR_EN) tx_frame[DW+1] = (^cur_byte) ^ ODD_PAR;
      bit_nxt     = bit_q + 1'b1;
   end

   uart_rx_frame #(
      .DIV       (DIV),
      .DATA_BITS (DW),
      .PAR_EN    (PAR_EN),
      .ODD_PAR   (ODD_PAR),
      .STOP_BITS (STOP_BITS)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .en_i       (rx_en),
      .rx_i       (rx),
      .start_ok_o (start_ok),
      .byte_o     (rx_byte),
      .byte_vld_o (byte_vld),
      .par_err_o  (par_err),
      .frm_err_o  (frm_err)
   );

   // Main FSM with the TX serialiser, response assembly and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_rdy_q <= 1'b1;
         tx_q      <= 1'b1;
         rw_q      <= 1'b0;
         cmd_sh_q  <= '0;
         tim_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         rx_cnt_q  <= '0;
         to_q      <= '0;
         rsp_q     <= '0;
         rsp_vld_q <= 1'b0;
         err_q     <= '0;
      end else begin
         rsp_vld_q <= 1'b0;
         if (accept) begin
            // Capture the command and drive its start bit from the next cycle.
            state_q   <= ST_TX_BYTE;
            cmd_rdy_q <= 1'b0;
            cmd_sh_q  <= cmd_data;
            rw_q      <= cmd_data[CW-1];
            tx_q      <= 1'b0;
            tim_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            rx_cnt_q  <= '0;
            to_q      <= '0;
            rsp_q     <= '0;
            err_q     <= '0;
         end else begin
            case (state_q)
               ST_IDLE: ;
               ST_TX_BYTE: begin
                  if (tim_q == TIM_MAX) begin
                     tim_q <= '0;
                     if (bit_q == BIT_LAST) begin
                        bit_q <= '0;
                        if (byte_q == CMD_LAST) begin
                           byte_q  <= '0;
                           tx_q    <= 1'b1;
                           state_q <= rw_q ? ST_RX_WAIT : ST_DONE;
                        end else begin
                           // Next byte starts immediately, no idle gap.
                           byte_q   <= byte_q + 1'b1;
                           cmd_sh_q <= cmd_sh_q << DW;
                           tx_q     <= 1'b0;
                        end
                     end else begin
                        bit_q <= bit_nxt;
                        tx_q  <= tx_frame[bit_nxt];
                     end
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               ST_RX_WAIT: begin
                  // Timeout takes priority over a start bit seen in the same cycle.
                  if (to_q == TO_MAX) begin
                     to_q           <= '0;
                     err_q[ERR_TMO] <= 1'b1;
                     rsp_vld_q      <= 1'b1;
                     cmd_rdy_q      <= 1'b1;
                     state_q        <= ST_DONE;
                  end else if (start_ok) begin
                     to_q    <= '0;
                     state_q <= ST_RX_BYTE;
                  end else begin
                     to_q <= to_q + 1'b1;
                  end
               end
               ST_RX_BYTE: begin
                  if (byte_vld) begin
                     for (int k = 0; k < RSP_BYTES; k++) begin
                        if (rx_cnt_q == RBW'(k)) rsp_q[RW-1-k*DW -: DW] <= rx_byte;
                     end
                     err_q[ERR_PAR] <= err_q[ERR_PAR] | par_err;
                     err_q[ERR_FRM] <= err_q[ERR_FRM] | frm_err;
                     if (rx_cnt_q == RSP_LAST) begin
                        rx_cnt_q  <= '0;
                        rsp_vld_q <= 1'b1;
                        cmd_rdy_q <= 1'b1;
                        state_q   <= ST_DONE;
                     end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                        state_q  <= ST_RX_WAIT;
                     end
                  end
               end
               ST_DONE: begin
                  cmd_rdy_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign cmd_rdy  = cmd_rdy_q;
   assign busy     = ~cmd_rdy_q;
   assign tx       = tx_q;
   assign rsp_data = rsp_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_err  = err_q;

endmodule
